// File: rtl/sseg_pkg.sv
// Shared types, segment constants and the hex-to-segment decoder
// for the four-digit seven-segment display driver.
package sseg_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [3:0] AN_OFF    = 4'hF;

    localparam int unsigned CONV_CYCLES = 16;

    // Active-low segments ordered {dp,g,f,e,d,c,b,a}; dp stays off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sseg_display_bin2bcd.sv
// Iterative 16-bit binary to 20-bit BCD converter (double-dabble),
// one shift per clock; START while busy restarts with the new value.
module bin2bcd
    import sseg_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [15:0] BIN,
    output logic        BUSY,
    output logic        DONE,
    output logic [19:0] BCD
);

    logic        busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [19:0] bcd_q, bcd_d;
    logic [15:0] sh_q, sh_d;
    logic [19:0] adj;

    always_comb begin
        adj = bcd_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end

        busy_d = busy_q;
        cnt_d  = cnt_q;
        bcd_d  = bcd_q;
        sh_d   = sh_q;

        // The first shift is folded into the load (scratch is zero, so no
        // add-3 applies), which lets the result land after 16 busy cycles.
        if (START) begin
            busy_d = 1'b1;
            cnt_d  = 5'd1;
            bcd_d  = {19'd0, BIN[15]};
            sh_d   = {BIN[14:0], 1'b0};
        end else if (busy_q) begin
            if (cnt_q == 5'(CONV_CYCLES)) begin
                busy_d = 1'b0;
            end else begin
                {bcd_d, sh_d} = {adj, sh_q} << 1;
                cnt_d         = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            bcd_q  <= '0;
            sh_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            bcd_q  <= bcd_d;
            sh_q   <= sh_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = busy_q && (cnt_q == 5'(CONV_CYCLES));
    assign BCD  = bcd_q;

endmodule

// File: rtl/sseg_display.sv
// Four-digit multiplexed seven-segment driver: latches a 16-bit value and
// shows it as hex or blank-suppressed unsigned decimal (dashes above 9999).
module sseg_display
    import sseg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic        WE,
    input  logic        MODE,
    output logic [3:0]  ANODES,
    output logic [7:0]  CATHODES,
    output logic        BUSY
);

    localparam int unsigned    CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    state_t            state_q, state_d;
    logic [3:0][3:0]   dig_q, dig_d;
    logic [3:0]        blank_q, blank_d;
    logic [3:0]        dash_q, dash_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        an_q, an_d;
    logic [7:0]        cath_q, cath_d;

    logic              conv_start;
    logic              conv_busy;
    logic              conv_done;
    logic              conv_fin;
    logic [19:0]       conv_bcd;

    assign conv_start = WE && MODE;

    bin2bcd u_bin2bcd (
        .CLK   (CLK),
        .RST   (RST),
        .START (conv_start),
        .BIN   (DATA),
        .BUSY  (conv_busy),
        .DONE  (conv_done),
        .BCD   (conv_bcd)
    );

    assign conv_fin = conv_busy && conv_done;

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        blank_d = blank_q;
        dash_d  = dash_q;

        // Any write abandons an in-flight conversion; a stale DONE from an
        // abandoned run is ignored because the FSM is back in IDLE.
        if (WE) begin
            if (MODE) begin
                state_d = CONVERT;
            end else begin
                state_d = IDLE;
                dig_d   = DATA;
                blank_d = '0;
                dash_d  = '0;
            end
        end else if (state_q == CONVERT && conv_fin) begin
            state_d = IDLE;
            dig_d   = conv_bcd[15:0];
            if (conv_bcd[19:16] != 4'd0) begin
                dash_d  = '1;
                blank_d = '0;
            end else begin
                dash_d     = '0;
                blank_d[3] = (conv_bcd[15:12] == 4'd0);
                blank_d[2] = blank_d[3] && (conv_bcd[11:8] == 4'd0);
                blank_d[1] = blank_d[2] && (conv_bcd[7:4] == 4'd0);
                blank_d[0] = 1'b0;
            end
        end

        busy_d = (state_d == CONVERT);
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        an_d   = AN_OFF;
        cath_d = SEG_BLANK;
        if (!blank_q[idx_q]) begin
            an_d[idx_q] = 1'b0;
            cath_d      = dash_q[idx_q] ? SEG_DASH : hex_to_seg(dig_q[idx_q]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            dig_q   <= '0;
            blank_q <= '0;
            dash_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= AN_OFF;
            cath_q  <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            blank_q <= blank_d;
            dash_q  <= dash_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            cath_q  <= cath_d;
        end
    end

    assign ANODES   = an_q;
    assign CATHODES = cath_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_sseg_display.sv
// Self-checking bench for sseg_display: behavioural model of the displayed
// digits checked every cycle, plus directed literal checks and random traffic.
module tb_sseg_display;

    localparam int unsigned DIV = 4;

    localparam logic [7:0] SEGS [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    localparam int unsigned P10 [4] = '{1, 10, 100, 1000};

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] DATA = '0;
    logic        WE = 1'b0;
    logic        MODE = 1'b0;
    logic [3:0]  ANODES;
    logic [7:0]  CATHODES;
    logic        BUSY;

    sseg_display #(.REFRESH_DIV(DIV)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DATA     (DATA),
        .WE       (WE),
        .MODE     (MODE),
        .ANODES   (ANODES),
        .CATHODES (CATHODES),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model state: what is on display, any pending decimal conversion,
    // and cycles elapsed since reset for the scan position.
    bit          m_valid = 0;
    int unsigned m_val = 0;
    bit          m_dec = 0;
    bit          conv_on = 0;
    int unsigned conv_val = 0;
    int unsigned conv_left = 0;
    int unsigned t = 0;
    logic [3:0]  exp_an;
    logic [7:0]  exp_cath;
    logic        exp_busy;

    logic [7:0]  obs_seen [4];
    bit          obs_lit [4];
    int unsigned obs_cnt [4];
    bit          obs_90;

    function automatic bit model_lit(int unsigned v, bit dec, int unsigned d);
        if (!dec || v > 9999) return 1'b1;
        return (d == 0) || (v >= P10[d]);
    endfunction

    function automatic logic [7:0] model_seg(int unsigned v, bit dec, int unsigned d);
        if (!dec) return SEGS[(v >> (4*d)) & 15];
        if (v > 9999) return 8'hBF;
        if (!model_lit(v, dec, d)) return 8'hFF;
        return SEGS[(v / P10[d]) % 10];
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit we, input bit mode, input logic [15:0] data);
        int unsigned idx;
        if (rst) begin
            m_val = 0; m_dec = 0; conv_on = 0; t = 0;
            exp_an = 4'hF; exp_cath = 8'hFF; exp_busy = 1'b0;
            m_valid = 1;
            return;
        end
        idx = (t / DIV) % 4;
        if (model_lit(m_val, m_dec, idx)) begin
            exp_an   = 4'hF & ~(4'b0001 << idx);
            exp_cath = model_seg(m_val, m_dec, idx);
        end else begin
            exp_an   = 4'hF;
            exp_cath = 8'hFF;
        end
        t++;
        if (we) begin
            if (mode) begin
                conv_on = 1; conv_val = data; conv_left = 16;
            end else begin
                conv_on = 0; m_val = data; m_dec = 0;
            end
        end else if (conv_on) begin
            conv_left--;
            if (conv_left == 0) begin
                conv_on = 0; m_val = conv_val; m_dec = 1;
            end
        end
        exp_busy = conv_on;
    endtask

    task automatic clear_obs();
        for (int d = 0; d < 4; d++) begin
            obs_seen[d] = 8'h00; obs_lit[d] = 0; obs_cnt[d] = 0;
        end
        obs_90 = 0;
    endtask

    task automatic step(input bit rst, input bit we, input bit mode, input logic [15:0] data);
        RST = rst; WE = we; MODE = mode; DATA = data;
        @(posedge CLK);
        #1;
        model_edge(rst, we, mode, data);
        @(negedge CLK);
        if (m_valid) begin
            cmp("anodes", ANODES, exp_an);
            cmp("cathodes", CATHODES, exp_cath);
            cmp("busy", BUSY, exp_busy);
        end
        for (int d = 0; d < 4; d++) begin
            if (ANODES[d] === 1'b0) begin
                obs_seen[d] = CATHODES; obs_lit[d] = 1; obs_cnt[d]++;
            end
        end
        if (CATHODES === 8'h90) obs_90 = 1;
        RST = 1'b0; WE = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 16'h0000);
    endtask

    // Issues a decimal write and returns how many cycles BUSY stayed high.
    task automatic dec_write(input logic [15:0] v, output int unsigned busy_cycles);
        int unsigned guard;
        step(0, 1, 1, v);
        busy_cycles = 0;
        guard = 0;
        while (BUSY === 1'b1 && guard < 40) begin
            busy_cycles++;
            guard++;
            step(0, 0, 0, 16'h0000);
        end
        if (guard >= 40) cmp("busy_timeout", guard, 0);
    endtask

    task automatic frame();
        idle(2);
        clear_obs();
        idle(4 * DIV);
    endtask

    initial begin
        int unsigned bc;
        logic [15:0] rv;

        clear_obs();
        step(1, 0, 0, 16'h0000);
        step(1, 0, 0, 16'h0000);
        cmp("reset_anodes", ANODES, 4'hF);
        cmp("reset_cathodes", CATHODES, 8'hFF);
        cmp("reset_busy", BUSY, 1'b0);
        step(0, 0, 0, 16'h0000);
        cmp("first_digit_an", ANODES, 4'b1110);
        cmp("first_digit_cath", CATHODES, 8'hC0);

        // Hex 1234
        step(0, 1, 0, 16'h1234);
        cmp("model_pin_hex_d3", model_seg(16'h1234, 0, 3), 8'hF9);
        frame();
        cmp("hex_d0", obs_seen[0], 8'h99);
        cmp("hex_d1", obs_seen[1], 8'hB0);
        cmp("hex_d2", obs_seen[2], 8'hA4);
        cmp("hex_d3", obs_seen[3], 8'hF9);
        for (int d = 0; d < 4; d++) cmp("hex_lit_cycles", obs_cnt[d], DIV);

        // Decimal 1234
        dec_write(16'd1234, bc);
        cmp("dec1234_busy_len", bc, 16);
        frame();
        cmp("dec1234_d0", obs_seen[0], 8'h99);
        cmp("dec1234_d1", obs_seen[1], 8'hB0);
        cmp("dec1234_d2", obs_seen[2], 8'hA4);
        cmp("dec1234_d3", obs_seen[3], 8'hF9);

        // Decimal 7
        dec_write(16'd7, bc);
        cmp("model_pin_dec7_d1", model_seg(7, 1, 1), 8'hFF);
        frame();
        cmp("dec7_d0", obs_seen[0], 8'hF8);
        cmp("dec7_d1_dark", obs_lit[1], 0);
        cmp("dec7_d2_dark", obs_lit[2], 0);
        cmp("dec7_d3_dark", obs_lit[3], 0);

        // Overflow dashes
        dec_write(16'd10000, bc);
        frame();
        for (int d = 0; d < 4; d++) cmp("dec10000_dash", obs_seen[d], 8'hBF);
        dec_write(16'd65535, bc);
        frame();
        for (int d = 0; d < 4; d++) cmp("dec65535_dash", obs_seen[d], 8'hBF);

        // Restart during conversion
        clear_obs();
        step(0, 1, 1, 16'd9999);
        idle(4);
        dec_write(16'd42, bc);
        cmp("restart_busy_len", bc, 16);
        frame();
        cmp("dec42_d0", obs_seen[0], 8'hA4);
        cmp("dec42_d1", obs_seen[1], 8'h99);
        cmp("dec42_d2_dark", obs_lit[2], 0);
        cmp("dec42_d3_dark", obs_lit[3], 0);
        cmp("no_9999_shown", obs_90, 0);

        // Reset mid-conversion, with a simultaneous write that must lose
        step(0, 1, 1, 16'd1234);
        idle(5);
        step(1, 1, 0, 16'hFFFF);
        cmp("midrst_anodes", ANODES, 4'hF);
        cmp("midrst_cathodes", CATHODES, 8'hFF);
        cmp("midrst_busy", BUSY, 1'b0);
        idle(1);
        clear_obs();
        idle(4 * DIV);
        for (int d = 0; d < 4; d++) cmp("post_rst_zero", obs_seen[d], 8'hC0);
        for (int d = 0; d < 4; d++) cmp("post_rst_lit", obs_lit[d], 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: rv = 16'($urandom_range(0, 65535));
                1: rv = 16'($urandom_range(0, 9));
                2: rv = 16'($urandom_range(0, 9999));
                default: rv = 16'($urandom_range(9990, 10010));
            endcase
            if ($urandom_range(0, 299) == 0)
                step(1, $urandom_range(0, 1) == 1, 1'b1, rv);
            else if ($urandom_range(0, 11) == 0)
                step(0, 1, $urandom_range(0, 1) == 1, rv);
            else
                step(0, 0, 0, rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
